// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its result buffer.
//   - opcode encodings, including the divide opcode and the illegal-opcode set
//   - operand/result widths
//   - packed buffer entry {opcode, result, zero, dbz, illegal}
package alu_pkg;

   localparam int ALU_W = 8;
   localparam int RES_W = 16;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_SHL  = 4'b1000;
   localparam logic [3:0] OP_SHR  = 4'b1001;
   localparam logic [3:0] OP_ROL  = 4'b1010;
   localparam logic [3:0] OP_ROR  = 4'b1011;
   localparam logic [3:0] OP_NAND = 4'b1100;
   localparam logic [3:0] OP_XNOR = 4'b1101;

   // Opcodes the ALU does not implement; it drives 0 for these.
   localparam logic [3:0] OP_ILL0 = 4'b0111;
   localparam logic [3:0] OP_ILL1 = 4'b1110;
   localparam logic [3:0] OP_ILL2 = 4'b1111;

   typedef struct packed {
      logic [3:0]       opcode;
      logic [RES_W-1:0] result;
      logic             zero;
      logic             dbz;
      logic             illegal;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   function automatic logic is_illegal(input logic [3:0] op);
      return (op == OP_ILL0) || (op == OP_ILL1) || (op == OP_ILL2);
   endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU, the result buffer and its consumer.
//   in_*  : ALU result push side (valid/ready)
//   out_* : head-of-queue drain side (valid/ready) with decoded flags
// slave modport is the buffer; master modport is the ALU/consumer side.
interface alu_result_buffer_if;
   import alu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_opcode;
   logic [ALU_W-1:0] in_b;
   logic [RES_W-1:0] in_result;

   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] out_result;
   logic [3:0]       out_opcode;
   logic             out_zero;
   logic             out_dbz;
   logic             out_illegal;

   modport slave (
      input  in_valid, in_opcode, in_b, in_result, out_ready,
      output in_ready, out_valid, out_result, out_opcode,
             out_zero, out_dbz, out_illegal
   );

   modport master (
      output in_valid, in_opcode, in_b, in_result, out_ready,
      input  in_ready, out_valid, out_result, out_opcode,
             out_zero, out_dbz, out_illegal
   );
endinterface

// File: rtl/alu_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO.
//   clk, rst          : clock, synchronous active-high reset
//   push, wr_data     : write request; ignored when full
//   pop               : read request; ignored when empty
//   rd_data           : head entry (raw storage, caller masks when empty)
//   count/full/empty  : occupancy
// Full/empty are decoded from count so the pointers may simply wrap.
module alu_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;   // a pop in the same cycle does not free a slot
   assign do_pop  = pop && !empty;
   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: reads are only meaningful while non-empty.
   always_ff @(posedge clk) begin
      if (!rst && do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/alu_result_buffer.sv
// ALU result buffer: tags each ALU result with status flags and queues it.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : slave side of the push/drain handshake bundle
//   count     : entries currently held
//   drop_cnt  : pushes refused because the queue was full (saturating)
// Outputs come straight from the head entry through a mask; no output register.
module alu_result_buffer
   import alu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   alu_result_buffer_if.slave       bus,
   output logic [$clog2(DEPTH):0]   count,
   output logic [DROP_W-1:0]        drop_cnt
);

   entry_t           wr_entry;
   entry_t           head;
   logic [ENTRY_W-1:0] rd_data;
   logic             full, empty;
   logic [DROP_W-1:0] drop_q, drop_d;

   // Flags are resolved at push time so in_b never has to be stored.
   always_comb begin
      wr_entry.opcode  = bus.in_opcode;
      wr_entry.result  = bus.in_result;
      wr_entry.zero    = (bus.in_result == '0);
      wr_entry.dbz     = (bus.in_opcode == OP_DIV) && (bus.in_b == '0);
      wr_entry.illegal = is_illegal(bus.in_opcode);
   end

   alu_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (bus.in_valid),
      .wr_data (wr_entry),
      .pop     (bus.out_ready),
      .rd_data (rd_data),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   assign head = entry_t'(rd_data);

   // Mask keeps stale or uninitialised storage off the outputs when empty.
   always_comb begin
      bus.in_ready    = !full;
      bus.out_valid   = !empty;
      bus.out_result  = empty ? '0 : head.result;
      bus.out_opcode  = empty ? '0 : head.opcode;
      bus.out_zero    = !empty && head.zero;
      bus.out_dbz     = !empty && head.dbz;
      bus.out_illegal = !empty && head.illegal;
   end

   always_comb begin
      drop_d = drop_q;
      if (bus.in_valid && full && (drop_q != '1)) drop_d = drop_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) drop_q <= '0;
      else     drop_q <= drop_d;
   end

   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_alu_result_buffer;

   localparam int DEPTH  = 4;
   localparam int DROP_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [$clog2(DEPTH):0] count;
   logic [DROP_W-1:0]      drop_cnt;

   alu_result_buffer_if bus ();

   alu_result_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .count    (count),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] res;
      bit          z;
      bit          d;
      bit          il;
   } exp_t;

   exp_t q[$];
   int   drops;
   int   n_vec;
   int   n_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   // Drive one cycle: set inputs on the falling edge, check outputs against
   // the model, then advance the model across the rising edge.
   task automatic step(input bit r, input bit v, input logic [3:0] op,
                       input logic [7:0] b, input logic [15:0] res, input bit rdy);
      exp_t e;
      bit   push, pop;
      @(negedge clk);
      rst           = r;
      bus.in_valid  = v;
      bus.in_opcode = op;
      bus.in_b      = b;
      bus.in_result = res;
      bus.out_ready = rdy;
      #1;
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("in_ready",  32'(bus.in_ready),  32'(q.size() < DEPTH));
      chk("count",     32'(count),         32'(q.size()));
      chk("drop_cnt",  32'(drop_cnt),      32'(drops));
      if (q.size() > 0) begin
         chk("out_result",  32'(bus.out_result),  32'(q[0].res));
         chk("out_opcode",  32'(bus.out_opcode),  32'(q[0].op));
         chk("out_zero",    32'(bus.out_zero),    32'(q[0].z));
         chk("out_dbz",     32'(bus.out_dbz),     32'(q[0].d));
         chk("out_illegal", 32'(bus.out_illegal), 32'(q[0].il));
      end else begin
         chk("empty_outs", {11'd0, bus.out_result, bus.out_opcode,
                            bus.out_zero, bus.out_dbz, bus.out_illegal}, 32'd0);
      end
      if (r) begin
         q.delete();
         drops = 0;
      end else begin
         push = v && (q.size() < DEPTH);
         pop  = rdy && (q.size() > 0);
         if (v && !push && drops < 255) drops++;
         if (pop) void'(q.pop_front());
         if (push) begin
            e.op  = op;
            e.res = res;
            e.z   = (res == 16'h0000);
            e.d   = (op == 4'd3) && (b == 8'd0);
            e.il  = (op == 4'd7) || (op == 4'd14) || (op == 4'd15);
            q.push_back(e);
         end
      end
      @(posedge clk);
   endtask

   task automatic idle(input bit rdy);
      step(1'b0, 1'b0, 4'd0, 8'd0, 16'd0, rdy);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      drops = 0;
      bus.in_valid  = 1'b0;
      bus.in_opcode = 4'd0;
      bus.in_b      = 8'd0;
      bus.in_result = 16'd0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state, then a single ADD result appearing one cycle later.
      step(1'b0, 1'b1, 4'b0000, 8'd1, 16'h0010, 1'b0);
      idle(1'b1);
      idle(1'b0);

      // Divide by zero vs. non-zero divisor.
      step(1'b0, 1'b1, 4'b0011, 8'd0, 16'h0000, 1'b0);
      step(1'b0, 1'b1, 4'b0011, 8'd4, 16'h0003, 1'b1);
      idle(1'b1);
      idle(1'b0);

      // Overfill with out_ready low: one drop, then a refused push while full
      // even though a pop happens the same cycle, then full drain to empty.
      for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 4'b0000, 8'd1, 16'(i), 1'b0);
      step(1'b0, 1'b1, 4'b0001, 8'd1, 16'h00AA, 1'b1);
      repeat (5) idle(1'b1);

      // Steady push+pop at count 2 across pointer wrap.
      step(1'b0, 1'b1, 4'b0100, 8'd1, 16'h0100, 1'b0);
      step(1'b0, 1'b1, 4'b0100, 8'd1, 16'h0101, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 4'b0101, 8'd1, 16'(16'h0200 + i), 1'b1);
      repeat (3) idle(1'b1);

      // Illegal opcodes (ALU drives 0).
      step(1'b0, 1'b1, 4'b0111, 8'd0, 16'h0000, 1'b0);
      step(1'b0, 1'b1, 4'b1110, 8'd0, 16'h0000, 1'b1);
      step(1'b0, 1'b1, 4'b1111, 8'd0, 16'h0000, 1'b1);
      repeat (2) idle(1'b1);

      // Reset with entries queued and a push pending; then first push after it.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0010, 8'd2, 16'(16'h0300 + i), 1'b0);
      step(1'b1, 1'b1, 4'b0010, 8'd2, 16'h0EEE, 1'b1);
      step(1'b0, 1'b1, 4'b0110, 8'd5, 16'h0777, 1'b0);
      idle(1'b0);

      // Drop counter saturation.
      step(1'b1, 1'b0, 4'd0, 8'd0, 16'd0, 1'b0);
      for (int i = 0; i < DEPTH + 260; i++) step(1'b0, 1'b1, 4'b1000, 8'd1, 16'(i), 1'b0);
      idle(1'b0);
      chk("drop_sat", 32'(drop_cnt), 32'h0000_00FF);

      // Random traffic with occasional reset.
      step(1'b1, 1'b0, 4'd0, 8'd0, 16'd0, 1'b0);
      for (int i = 0; i < 600; i++) begin
         logic [3:0]  op;
         logic [7:0]  b;
         logic [15:0] res;
         op  = 4'($urandom_range(0, 15));
         b   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
         res = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
         if (op == 4'd7 || op == 4'd14 || op == 4'd15) res = 16'd0;
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), op, b, res,
              ($urandom_range(0, 1) == 1));
      end
      repeat (DEPTH + 1) idle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
